instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch and program-load unit for the 15-puzzle core. It is the producer end of the decoder's instruction interface. It holds a 512 x 23-bit instruction memory, filled through a valid/ready load port, and a 9-bit program counter. While running it presents `op` to the decoder every cycle and consumes the decoder's `pc_in`/`pc_we` redirect. It halts when execution leaves the loaded program.

## Interface
Parameters:
- `OP_W`, 23, instruction width; opcode field is `[22:18]`.
- `PC_W`, 9, program counter width.
- `DEPTH`, 512, instruction memory depth; equals 2**PC_W.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ld_start`  in  1  pulse; in IDLE, begins a new program load.
- `ld_valid`  in  1  load beat valid.
- `ld_ready`  out  1  load beat accepted; high only in LOAD.
- `ld_data`  in  OP_W  instruction word.
- `ld_last`  in  1  marks the final beat of the program.
- `run`  in  1  pulse; in IDLE with `prog_len`>0, starts execution at pc 0.
- `abort`  in  1  level; in RUN or HALT, returns to IDLE.
- `pc_in`  in  PC_W  jump target from the decoder.
- `pc_we`  in  1  jump taken, from the decoder.
- `op`  out  OP_W  current instruction to the decoder.
- `op_valid`  out  1  `op` is executable; top level gates `reg_we`/`mem_we` with it.
- `pc`  out  PC_W  current program counter.
- `prog_len`  out  PC_W+1  number of loaded words, 0..512.
- `halted`  out  1  high in HALT.

## Operation
- States are IDLE, LOAD, RUN and HALT.
- IDLE:
  - `ld_start` goes to LOAD; `wr_ptr`<=0 and `prog_len`<=0.
  - Otherwise `run` with `prog_len`!=0 goes to RUN with `pc`<=0.
  - `run` with `prog_len`==0 is ignored.
  - `ld_start` has priority over `run`.
- LOAD:
  - `ld_ready`=1. A beat is accepted when `ld_valid & ld_ready`.
  - An accepted beat does `mem[wr_ptr]`<=`ld_data`, `wr_ptr`++ and `prog_len`<=`wr_ptr`+1.
  - The state returns to IDLE on an accepted beat that has `ld_last`=1, or on an accepted beat with `wr_ptr`==511 (memory full, auto-terminate).
  - `ld_valid` low simply waits; there is no timeout.
- RUN:
  - `op`=`mem[pc]`, read combinationally; `op_valid`=1.
  - Each cycle `pc` <= `pc_we` ? `pc_in` : `pc`+1.
  - The next pc is computed at PC_W+1 bits. If it is >= `prog_len`, the state goes to HALT, and `pc` holds its last executed value. This covers the wrap from 511, a jump out of range, and fall-through past the last word.
- HALT: `halted`=1; `pc` is frozen.
- Outputs outside RUN: `op`=0 and `op_valid`=0.
- `abort` in RUN or HALT goes to IDLE next edge. `abort` beats `pc_we`. `abort` is ignored in LOAD and IDLE.
- `pc_we` and `pc_in` are ignored outside RUN.
- Memory contents survive reset and abort. Only a new LOAD overwrites them; words beyond the new `prog_len` are stale but unreachable.

## Timing
- Reset values: state IDLE, `pc`=0, `wr_ptr`=0, `prog_len`=0, `op`=0, `op_valid`=0, `ld_ready`=0, `halted`=0.
- Fetch latency is 0: `op` follows `pc` combinationally. The decoder's `pc_we` therefore acts on the same cycle's `op`, and the target instruction appears on the next cycle. There is no delay slot.
- `run` accepted at edge N: `op_valid`=1 with `pc`=0 from cycle N+1.
- Load throughput is one word per cycle. `ld_ready` rises the cycle after `ld_start` and falls the cycle after the terminating beat.
- A word written at edge N is readable from cycle N+1. RUN cannot start before N+1 anyway.
- The HALT transition is registered. The out-of-range instruction is never presented with `op_valid`=1.
- `rst` mid-LOAD: the load is discarded, `prog_len`=0, and `run` is refused until a reload.

## Structure
- Shared package `puzzle_pkg`:
  - `OP_W` and `PC_W` constants.
  - The opcode field slice (`[22:18]`).
  - Fetch state enum `fetch_state_t` {IDLE, LOAD, RUN, HALT}.
  - The opcode constants are shared with the decoder.
- Sub-module `instr_mem`: DEPTH x OP_W, with one synchronous write port and one asynchronous read port, and no reset. The FSM, pointers and pc logic stay in `instr_fetch`.

## Test plan
- Load and run: load 4 words 0x000001..0x000004 with `ld_last` on the 4th beat, then `run` → `prog_len`=4; `op` equals the words in order at pc 0..3; HALT after the cycle with pc 3; `op`=0.
- Jump: load 6 words, run, drive `pc_we`=1 and `pc_in`=5 while pc=1 → next `pc`=5 and `op`=word5; the following cycle gives HALT.
- Out-of-range jump: `prog_len`=6, `pc_we`=1 with `pc_in`=100 → HALT next edge; `pc` holds the jumping pc; `op_valid` never 1 at pc 100.
- Full load: 512 beats with `ld_last` never asserted → auto IDLE after beat 511; `prog_len`=512. Run with no jumps → pc 0..511, then HALT (wrap detected).
- Back-pressure and boundary: `ld_valid` toggling 1,0,1 gives no write on idle cycles. `run` with `prog_len`=0 stays IDLE. `ld_start` and `run` in the same cycle gives LOAD.
- Reset and abort: `rst` after 2 of 5 beats → IDLE, `prog_len`=0, `ld_ready`=0. `abort` and `pc_we` in the same RUN cycle → IDLE with `op_valid`=0; memory is retained, and a rerun reproduces the original op sequence.

Source files
------------

// File: rtl/puzzle_pkg.sv
// Shared definitions for the 15-puzzle core: datapath widths, the opcode
// field location and the fetch unit state encoding.
package puzzle_pkg;

    localparam int OP_W   = 23;
    localparam int PC_W   = 9;
    localparam int OPC_HI = 22;
    localparam int OPC_LO = 18;
    localparam int OPC_W  = OPC_HI - OPC_LO + 1;

    typedef logic [OPC_W-1:0] opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } fetch_state_t;

    function automatic opcode_t opcode_of(input logic [OP_W-1:0] instr);
        return instr[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/instr_mem.sv
// Instruction store: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so a program survives reset and abort.
module instr_mem
    import puzzle_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AW    = PC_W
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [OP_W-1:0] wdata_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [OP_W-1:0] rdata_o
);

    logic [OP_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch and program-load unit: loads the instruction memory over
// a valid/ready port, then streams mem[pc] to the decoder until pc leaves the program.
module instr_fetch #(
    parameter int OP_W  = 23,
    parameter int PC_W  = 9,
    parameter int DEPTH = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [OP_W-1:0]   ld_data,
    input  logic              ld_last,
    input  logic              run,
    input  logic              abort,
    input  logic [PC_W-1:0]   pc_in,
    input  logic              pc_we,
    output logic [OP_W-1:0]   op,
    output logic              op_valid,
    output logic [PC_W-1:0]   pc,
    output logic [PC_W:0]     prog_len,
    output logic              halted
);
    import puzzle_pkg::*;

    fetch_state_t    state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] wr_ptr_q;
    logic [PC_W:0]   prog_len_q;
    logic            ld_ready_q;
    logic            op_valid_q;
    logic            halted_q;

    logic [PC_W:0]   pc_d;
    logic [PC_W:0]   wr_cnt_d;
    logic            beat_d;
    logic [OP_W-1:0] rdata;

    // Next pc is one bit wider than pc so the wrap past the top of memory
    // compares as out of range instead of silently returning to 0.
    assign pc_d     = pc_we ? {1'b0, pc_in} : ({1'b0, pc_q} + (PC_W+1)'(1));
    assign wr_cnt_d = {1'b0, wr_ptr_q} + (PC_W+1)'(1);
    assign beat_d   = (state_q == LOAD) && ld_valid && ld_ready_q;

    instr_mem #(
        .DEPTH (DEPTH),
        .AW    (PC_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (beat_d),
        .waddr_i (wr_ptr_q),
        .wdata_i (ld_data),
        .raddr_i (pc_q),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            wr_ptr_q   <= '0;
            prog_len_q <= '0;
            ld_ready_q <= 1'b0;
            op_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ld_start) begin
                        state_q    <= LOAD;
                        wr_ptr_q   <= '0;
                        prog_len_q <= '0;
                        ld_ready_q <= 1'b1;
                    end else if (run && (prog_len_q != '0)) begin
                        state_q    <= RUN;
                        pc_q       <= '0;
                        op_valid_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (beat_d) begin
                        wr_ptr_q   <= wr_cnt_d[PC_W-1:0];
                        prog_len_q <= wr_cnt_d;
                        if (ld_last || (wr_ptr_q == PC_W'(DEPTH - 1))) begin
                            state_q    <= IDLE;
                            ld_ready_q <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q    <= IDLE;
                        op_valid_q <= 1'b0;
                    end else if (pc_d >= prog_len_q) begin
                        state_q    <= HALT;
                        op_valid_q <= 1'b0;
                        halted_q   <= 1'b1;
                    end else begin
                        pc_q <= pc_d[PC_W-1:0];
                    end
                end
                HALT: begin
                    if (abort) begin
                        state_q  <= IDLE;
                        halted_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign op       = op_valid_q ? rdata : '0;
    assign op_valid = op_valid_q;
    assign pc       = pc_q;
    assign prog_len = prog_len_q;
    assign ld_ready = ld_ready_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus pushes expected {pc, op} pairs,
// a negedge monitor pops and compares whenever op_valid is high.
module tb_instr_fetch;

    localparam int OP_W = 23;
    localparam int PC_W = 9;

    logic            clk;
    logic            rst;
    logic            ld_start;
    logic            ld_valid;
    logic            ld_ready;
    logic [OP_W-1:0] ld_data;
    logic            ld_last;
    logic            run;
    logic            abort;
    logic [PC_W-1:0] pc_in;
    logic            pc_we;
    logic [OP_W-1:0] op;
    logic            op_valid;
    logic [PC_W-1:0] pc;
    logic [PC_W:0]   prog_len;
    logic            halted;

    int vectors     = 0;
    int miscompares = 0;

    logic [OP_W-1:0] prog [512];
    logic [31:0]     expQ [$];

    instr_fetch #(
        .OP_W  (OP_W),
        .PC_W  (PC_W),
        .DEPTH (512)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .run      (run),
        .abort    (abort),
        .pc_in    (pc_in),
        .pc_we    (pc_we),
        .op       (op),
        .op_valid (op_valid),
        .pc       (pc),
        .prog_len (prog_len),
        .halted   (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Every presented instruction must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && op_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected fetch {pc,op}", {pc, op}, 32'hFFFF_FFFF);
            end else begin
                checkOutput("fetch {pc,op}", {pc, op}, expQ.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int n, input bit useLast);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            ld_valid = 1'b1;
            ld_data  = prog[i];
            ld_last  = useLast && (i == n - 1);
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        ld_data  = '0;
    endtask

    task automatic pushExp(input int p);
        expQ.push_back({PC_W'(p), prog[p]});
    endtask

    task automatic startRun(input int n);
        for (int i = 0; i < n; i++) pushExp(i);
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic waitHalt(input int budget);
        int k;
        k = 0;
        while (!halted && k < budget) begin
            tick();
            k++;
        end
        checkOutput("halt reached in budget", 32'(halted), 32'd1);
    endtask

    task automatic doAbort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ld_start = 0; ld_valid = 0; ld_data = '0; ld_last = 0;
        run = 0; abort = 0; pc_in = '0; pc_we = 0;
        tick(); tick();
        rst = 1'b0;

        checkOutput("reset op_valid", 32'(op_valid), 0);
        checkOutput("reset op", 32'(op), 0);
        checkOutput("reset ld_ready", 32'(ld_ready), 0);
        checkOutput("reset halted", 32'(halted), 0);
        checkOutput("reset prog_len", 32'(prog_len), 0);
        checkOutput("reset pc", 32'(pc), 0);

        // run with nothing loaded is refused
        run = 1'b1; tick(); run = 1'b0; tick();
        checkOutput("empty run op_valid", 32'(op_valid), 0);
        checkOutput("empty run halted", 32'(halted), 0);

        // load 4 and run to completion
        for (int i = 0; i < 4; i++) prog[i] = 23'(i + 1);
        applyStimulus(4, 1'b1);
        checkOutput("load4 prog_len", 32'(prog_len), 4);
        checkOutput("load4 ld_ready low", 32'(ld_ready), 0);
        startRun(4);
        waitHalt(10);
        checkOutput("load4 halt pc", 32'(pc), 3);
        checkOutput("load4 halt op", 32'(op), 0);
        checkOutput("load4 queue drained", 32'(expQ.size()), 0);
        tick();
        checkOutput("halt pc frozen", 32'(pc), 3);
        doAbort();
        checkOutput("abort from halt", 32'(halted), 0);

        // jump from pc 1 to the last word
        for (int i = 0; i < 6; i++) prog[i] = 23'h100000 + 23'(i * 'h11);
        applyStimulus(6, 1'b1);
        checkOutput("load6 prog_len", 32'(prog_len), 6);
        pushExp(0); pushExp(1); pushExp(5);
        run = 1'b1; tick(); run = 1'b0;
        tick();
        pc_we = 1'b1; pc_in = 9'd5; tick(); pc_we = 1'b0;
        checkOutput("jump pc", 32'(pc), 5);
        waitHalt(4);
        checkOutput("jump halt pc", 32'(pc), 5);
        checkOutput("jump queue drained", 32'(expQ.size()), 0);
        doAbort();

        // out-of-range jump halts without presenting the target
        pushExp(0); pushExp(1);
        run = 1'b1; tick(); run = 1'b0;
        tick();
        pc_we = 1'b1; pc_in = 9'd100; tick(); pc_we = 1'b0;
        checkOutput("oor halted", 32'(halted), 1);
        checkOutput("oor pc holds", 32'(pc), 1);
        checkOutput("oor op_valid", 32'(op_valid), 0);
        checkOutput("oor queue drained", 32'(expQ.size()), 0);
        doAbort();

        // back-pressure: the idle beat must not write
        prog[0] = 23'h0ABCDE; prog[1] = 23'h012345; prog[2] = 23'h6789AB;
        ld_start = 1'b1; run = 1'b1; tick(); ld_start = 1'b0; run = 1'b0;
        checkOutput("start beats run", 32'(ld_ready), 1);
        checkOutput("start beats run op_valid", 32'(op_valid), 0);
        ld_valid = 1; ld_data = prog[0]; tick();
        ld_valid = 0; ld_data = 23'h7FFFFF; tick();
        ld_valid = 1; ld_data = prog[1]; tick();
        ld_data = prog[2]; ld_last = 1; tick();
        ld_valid = 0; ld_last = 0; ld_data = '0;
        checkOutput("bp prog_len", 32'(prog_len), 3);
        startRun(3);
        waitHalt(8);
        checkOutput("bp queue drained", 32'(expQ.size()), 0);
        doAbort();

        // full memory with auto-terminate, run wraps into halt
        for (int i = 0; i < 512; i++) prog[i] = 23'((i * 32'h2A5B3) ^ 32'h15A5A5);
        applyStimulus(512, 1'b0);
        checkOutput("full prog_len", 32'(prog_len), 512);
        checkOutput("full ld_ready low", 32'(ld_ready), 0);
        startRun(512);
        waitHalt(600);
        checkOutput("full halt pc", 32'(pc), 511);
        checkOutput("full queue drained", 32'(expQ.size()), 0);
        doAbort();

        // reset mid-load discards the load
        for (int i = 0; i < 5; i++) prog[i] = 23'h200000 + 23'(i);
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        ld_valid = 1; ld_data = prog[0]; tick();
        ld_data = prog[1]; tick();
        ld_valid = 0;
        rst = 1'b1; tick(); rst = 1'b0;
        checkOutput("rst mid-load prog_len", 32'(prog_len), 0);
        checkOutput("rst mid-load ld_ready", 32'(ld_ready), 0);
        run = 1'b1; tick(); run = 1'b0; tick();
        checkOutput("rst mid-load run refused", 32'(op_valid), 0);

        // abort beats pc_we; rerun reproduces the program
        for (int i = 0; i < 4; i++) prog[i] = 23'h3F0000 | 23'(i * 'h101);
        applyStimulus(4, 1'b1);
        pushExp(0); pushExp(1);
        run = 1'b1; tick(); run = 1'b0;
        tick();
        abort = 1'b1; pc_we = 1'b1; pc_in = 9'd3; tick();
        abort = 1'b0; pc_we = 1'b0;
        checkOutput("abort op_valid", 32'(op_valid), 0);
        checkOutput("abort op", 32'(op), 0);
        checkOutput("abort halted", 32'(halted), 0);
        checkOutput("abort queue drained", 32'(expQ.size()), 0);
        startRun(4);
        waitHalt(10);
        checkOutput("rerun halt pc", 32'(pc), 3);
        checkOutput("rerun queue drained", 32'(expQ.size()), 0);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
